dw_batch_accum: RTL and testbench
=================================

// Module: dw_batch_accum
// PURPOSE
//  Weight-gradient generator for the DQN backprop path, multi-lane and batched.
//  Per sample: one delta (node error) times LANES activations a[i] gives LANES
//  products dw[i]=delta*a[i], fixed-point Q(W-FRAC).FRAC. Products accumulate over
//  a programmable mini-batch, are scaled by a learning-rate right shift, and are
//  emitted once per batch to the weight-update stage over a valid/ready handshake.
// PARAMETERS
//  W      16  data width of delta, a, dw (signed two's complement)
//  FRAC   10  fractional bits (default Q6.10)
//  LANES  4   activations/gradients processed in parallel per sample
//  ACC_W  24  per-lane accumulator width (signed), ACC_W >= W+2
// PORTS
//  clk        in   1         clock, all state on rising edge
//  rst        in   1         reset, synchronous, active-high
//  start      in   1         pulse: begin new batch (honoured in IDLE only)
//  cfg_batch  in   8         samples per batch, latched on start; 0 treated as 1
//  cfg_lr_sh  in   4         learning-rate right shift, latched on start
//  in_valid   in   1         sample valid
//  in_ready   out  1         sample accepted when in_valid & in_ready at clk edge
//  delta      in   W         node error, signed
//  a_in       in   LANES*W   activations, lane i = a_in[i*W +: W]
//  out_valid  out  1         gradient vector valid, held until accepted
//  out_ready  in   1         downstream accept
//  dw_out     out  LANES*W   scaled gradients, lane i = dw_out[i*W +: W]
//  busy       out  1         high in any state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, out_valid, busy=0; dw_out=0; accumulators,
//   sample counter, pipeline valids cleared. Reset mid-batch discards the batch.
//  FSM: IDLE -start-> ACCUM (latch cfg, clear acc, count=0).
//   ACCUM: in_ready=1 while count<batch; each handshake increments count.
//   count==batch -> DRAIN (in_ready=0) until pipeline empty -> OUTPUT.
//   OUTPUT: out_valid=1, dw_out stable; out_valid&out_ready -> IDLE.
//   start outside IDLE ignored; in_valid outside ACCUM ignored.
//  Pipeline: handshake at edge k -> product reg at k; accumulate at k+1;
//   for the last sample, dw_out/out_valid registered at edge k+2.
//  Arithmetic per lane:
//   p = delta*a (2W signed, full product); q = (p + 2^(FRAC-1)) >>> FRAC
//   (round half up, arithmetic shift); acc += sext(q), saturating at ACC_W
//   bounds (no wrap); out = (acc + round) >>> lr_sh (no rounding when lr_sh=0),
//   then saturate to W: max 2^(W-1)-1, min -2^(W-1).
//  Saturation is per lane, independent; other lanes unaffected.
//  out_ready high in same cycle out_valid rises: accepted that edge, back to IDLE.
//  start in the cycle of the OUTPUT handshake is ignored (state not yet IDLE).
// STRUCTURE
//  Package dqn_fixed_pkg: W/FRAC defaults, Q-format constants (ONE = 1<<FRAC),
//   state enum {IDLE,ACCUM,DRAIN,OUTPUT}, functions sat_to_w, round_shift.
//  Sub-module dw_lane_mac (one per lane, generate loop): product reg, round,
//   saturating accumulate, final shift+saturate. Top holds FSM, counter, handshakes.
// TESTING
//  1 batch=1, lr_sh=0, delta=0x0200 (0.5), all a=0x0800 (2.0) -> dw=0x0400 each lane,
//    out_valid 2 edges after handshake edge.
//  2 batch=4, lr_sh=0, delta=0x1000 (4.0), a=0x0800 x4 -> sum 32.0 > max -> 0x7FFF;
//    repeat lr_sh=2 -> 0x2000 (8.0); lane with a=0xF800 -> 0x8000 / 0xE000.
//  3 Rounding: delta=0xFFFF, a=0x0200 -> q=0 (-0.5 LSB rounds up); a=0x0600 -> q=-1.
//  4 Backpressure: hold out_ready=0 5 cycles -> out_valid=1, dw_out stable, in_ready=0,
//    start ignored; out_ready=1 -> IDLE next edge.
//  5 Gaps: in_valid toggled 1,0,1,0 in batch=3 -> exactly 3 samples summed; cfg_batch=0
//    -> behaves as batch=1.
//  6 rst asserted after 2 of 4 samples -> all outputs 0 next edge; new batch result
//    excludes the discarded samples.

Source files
------------

// File: rtl/dqn_fixed_pkg.sv
// Shared fixed-point definitions for the DQN backprop datapath.
//  - Default Q-format widths (Q6.10) and the fixed-point ONE constant
//  - Batch-accumulator FSM state encoding
//  - sat_to_w   : clamp a wide signed value to a w-bit signed range
//  - round_shift: arithmetic right shift with round-half-up (no bias when sh=0)
package dqn_fixed_pkg;

  localparam int W_DEF     = 16;
  localparam int FRAC_DEF  = 10;
  localparam int LANES_DEF = 4;
  localparam int ACC_W_DEF = 24;

  // Fixed-point 1.0 in the default format
  localparam int ONE = 32'sd1 <<< FRAC_DEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  // Clamp x into [-2^(w-1), 2^(w-1)-1]
  function automatic logic signed [63:0] sat_to_w(input logic signed [63:0] x,
                                                  input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) begin
      sat_to_w = hi;
    end else if (x < lo) begin
      sat_to_w = lo;
    end else begin
      sat_to_w = x;
    end
  endfunction

  // (x + 2^(sh-1)) >>> sh, plain pass-through when sh == 0
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] x,
                                                     input int sh);
    logic signed [63:0] bias;
    if (sh == 0) begin
      bias = 64'sd0;
    end else begin
      bias = 64'sd1 <<< (sh - 1);
    end
    round_shift = (x + bias) >>> sh;
  endfunction

endpackage

// File: rtl/dw_lane_mac.sv
// One gradient lane: registered product delta*a, rounding to the data Q-format,
// saturating accumulation across the batch, and final learning-rate shift with
// saturation to W bits.
// Ports:
//  clk, rst      clock / synchronous active-high reset
//  clr           clear accumulator (new batch)
//  cap           capture delta*a into the product register (sample handshake)
//  acc_en        add the rounded product register into the accumulator
//  load          register the scaled, saturated accumulator onto dw_out
//  lr_sh         learning-rate right shift
//  delta, a      signed sample operands
//  dw_out        scaled gradient for this lane (held between loads)
module dw_lane_mac
  import dqn_fixed_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         cap,
  input  logic         acc_en,
  input  logic         load,
  input  logic [3:0]   lr_sh,
  input  logic [W-1:0] delta,
  input  logic [W-1:0] a,
  output logic [W-1:0] dw_out
);

  logic signed [2*W-1:0] p_r;
  logic signed [ACC_W-1:0] acc_r;
  logic [W-1:0] dw_r;

  logic signed [63:0] p_ext_s;
  logic signed [63:0] q_s;
  logic signed [63:0] acc_ext_s;
  logic signed [63:0] sum_s;
  logic signed [63:0] out_s;

  // Datapath arithmetic: rounded product, saturated sum, scaled output
  always_comb begin
    p_ext_s   = 64'(p_r);
    q_s       = round_shift(p_ext_s, FRAC);
    acc_ext_s = 64'(acc_r);
    sum_s     = sat_to_w(acc_ext_s + q_s, ACC_W);
    out_s     = sat_to_w(round_shift(acc_ext_s, int'(lr_sh)), W);
  end

  // Product, accumulator and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      p_r   <= '0;
      acc_r <= '0;
      dw_r  <= '0;
    end else begin
      if (cap) begin
        // Operands widened to 2W so the full signed product is kept
        p_r <= $signed({{W{delta[W-1]}}, delta}) * $signed({{W{a[W-1]}}, a});
      end
      if (clr) begin
        acc_r <= '0;
      end else if (acc_en) begin
        acc_r <= ACC_W'(sum_s);
      end
      if (load) begin
        dw_r <= W'(out_s);
      end
    end
  end

  assign dw_out = dw_r;

endmodule

// File: rtl/dw_batch_accum.sv
// Batched multi-lane weight-gradient generator. Each accepted sample produces
// LANES products delta*a[i]; these are accumulated over a mini-batch, scaled by
// a learning-rate shift and presented once per batch on a valid/ready port.
// Ports:
//  clk, rst            clock / synchronous active-high reset
//  start               begin a batch (IDLE only); latches cfg_batch, cfg_lr_sh
//  cfg_batch           samples per batch (0 behaves as 1)
//  cfg_lr_sh           learning-rate right shift
//  in_valid/in_ready   sample handshake; delta and a_in (lane i = a_in[i*W +: W])
//  out_valid/out_ready gradient handshake; dw_out (lane i = dw_out[i*W +: W])
//  busy                high whenever not IDLE
module dw_batch_accum
  import dqn_fixed_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int LANES = LANES_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         cfg_batch,
  input  logic [3:0]         cfg_lr_sh,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       delta,
  input  logic [LANES*W-1:0] a_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] dw_out,
  output logic               busy
);

  state_t     state_r, state_nx;
  logic [7:0] count_r, count_nx;
  logic [7:0] batch_r, batch_nx;
  logic [3:0] lr_sh_r, lr_sh_nx;
  logic       pv_r;
  logic       in_ready_r;
  logic       out_valid_r;
  logic       busy_r;
  logic       fire_s;
  logic       clr_s;
  logic       load_s;

  // in_ready_r is only ever high in ACCUM with room left, so this is the full accept condition
  assign fire_s = in_valid & in_ready_r;

  // Next-state and control decode
  always_comb begin
    state_nx = state_r;
    count_nx = count_r;
    batch_nx = batch_r;
    lr_sh_nx = lr_sh_r;
    clr_s    = 1'b0;
    load_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx = ACCUM;
          count_nx = 8'd0;
          batch_nx = (cfg_batch == 8'd0) ? 8'd1 : cfg_batch;
          lr_sh_nx = cfg_lr_sh;
          clr_s    = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      ACCUM: begin
        if (fire_s) begin
          count_nx = count_r + 8'd1;
        end else begin
          count_nx = count_r;
        end
        // Leaves one edge after the last handshake, as that product lands in acc
        if (count_r == batch_r) begin
          state_nx = DRAIN;
        end else begin
          state_nx = ACCUM;
        end
      end
      DRAIN: begin
        if (!pv_r) begin
          state_nx = OUTPUT;
          load_s   = 1'b1;
        end else begin
          state_nx = DRAIN;
        end
      end
      OUTPUT: begin
        if (out_valid_r && out_ready) begin
          state_nx = IDLE;
        end else begin
          state_nx = OUTPUT;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, configuration, pipeline valid and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      count_r     <= 8'd0;
      batch_r     <= 8'd1;
      lr_sh_r     <= 4'd0;
      pv_r        <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx;
      count_r     <= count_nx;
      batch_r     <= batch_nx;
      lr_sh_r     <= lr_sh_nx;
      pv_r        <= fire_s;
      in_ready_r  <= (state_nx == ACCUM) && (count_nx < batch_nx);
      out_valid_r <= (state_nx == OUTPUT);
      busy_r      <= (state_nx != IDLE);
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    dw_lane_mac #(
      .W    (W),
      .FRAC (FRAC),
      .ACC_W(ACC_W)
    ) u_mac (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr_s),
      .cap   (fire_s),
      .acc_en(pv_r),
      .load  (load_s),
      .lr_sh (lr_sh_r),
      .delta (delta),
      .a     (a_in[i*W +: W]),
      .dw_out(dw_out[i*W +: W])
    );
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_dw_batch_accum.sv
module tb_dw_batch_accum;

  localparam int W     = 16;
  localparam int LANES = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [7:0]         cfg_batch;
  logic [3:0]         cfg_lr_sh;
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       delta;
  logic [LANES*W-1:0] a_in;
  logic               out_valid;
  logic               out_ready;
  logic [LANES*W-1:0] dw_out;
  logic               busy;

  int checks   = 0;
  int failures = 0;
  int pushed   = 0;
  int popped   = 0;
  logic [LANES*W-1:0] sb_q[$];

  always #5 clk = ~clk;

  dw_batch_accum dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cfg_batch(cfg_batch),
    .cfg_lr_sh(cfg_lr_sh),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .delta    (delta),
    .a_in     (a_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dw_out   (dw_out),
    .busy     (busy)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [15:0] l3, input logic [15:0] l2,
                                     input logic [15:0] l1, input logic [15:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  // Monitor: pops the scoreboard on every output handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_out", 64'(out_valid), 64'd0);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        popped++;
        chk("sb_dw_out", dw_out, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [63:0] e);
    sb_q.push_back(e);
    pushed++;
  endtask

  task automatic do_start(input logic [7:0] b, input logic [3:0] lr);
    cfg_batch = b;
    cfg_lr_sh = lr;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic [63:0] a);
    bit ok;
    ok       = 1'b0;
    delta    = d;
    a_in     = a;
    in_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_in_ready_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    delta    = 16'h7FFF;
    a_in     = 64'h7FFF_7FFF_7FFF_7FFF;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    if (!out_valid) chk("wait_out_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("accept_busy", 64'(busy), 64'd0);
    chk("accept_out_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    int n;
    logic [63:0] a_v;
    logic [63:0] e4;
    rst       = 1'b1;
    start     = 1'b0;
    cfg_batch = 8'd0;
    cfg_lr_sh = 4'd0;
    in_valid  = 1'b0;
    delta     = 16'h0000;
    a_in      = 64'h0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dw_out", dw_out, 64'd0);
    rst = 1'b0;
    tick();

    // 1: single sample, 0.5 * 2.0 = 1.0 per lane, output 2 edges after handshake
    do_start(8'd1, 4'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_in_ready", 64'(in_ready), 64'd1);
    expect_out(mk(16'h0400, 16'h0400, 16'h0400, 16'h0400));
    send(16'h0200, mk(16'h0800, 16'h0800, 16'h0800, 16'h0800));
    wait_out(n);
    chk("t1_latency", 64'(n), 64'd2);
    chk("t1_in_ready_out", 64'(in_ready), 64'd0);
    accept();

    // 2: saturation to W, lane1 negative
    a_v = mk(16'h0800, 16'h0800, 16'hF800, 16'h0800);
    do_start(8'd4, 4'd0);
    expect_out(mk(16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF));
    for (int i = 0; i < 4; i++) send(16'h1000, a_v);
    wait_out(n);
    accept();
    do_start(8'd4, 4'd2);
    expect_out(mk(16'h2000, 16'h2000, 16'hE000, 16'h2000));
    for (int i = 0; i < 4; i++) send(16'h1000, a_v);
    wait_out(n);
    accept();

    // 3: product rounding, -0.5 LSB -> 0, -1.5 LSB -> -1
    do_start(8'd1, 4'd0);
    expect_out(mk(16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000));
    send(16'hFFFF, mk(16'h0600, 16'h0200, 16'h0600, 16'h0200));
    wait_out(n);
    accept();

    // 4: backpressure, output held, start ignored
    e4 = mk(16'h0140, 16'h0280, 16'h03C0, 16'h0500);
    do_start(8'd2, 4'd1);
    expect_out(e4);
    send(16'h0400, mk(16'h0100, 16'h0200, 16'h0300, 16'h0400));
    send(16'h0600, mk(16'h0100, 16'h0200, 16'h0300, 16'h0400));
    wait_out(n);
    cfg_batch = 8'd1;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      tick();
      chk("t4_hold_valid", 64'(out_valid), 64'd1);
      chk("t4_hold_dw", dw_out, e4);
      chk("t4_hold_in_ready", 64'(in_ready), 64'd0);
      chk("t4_hold_busy", 64'(busy), 64'd1);
    end
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    chk("t4_idle_busy", 64'(busy), 64'd0);
    chk("t4_idle_valid", 64'(out_valid), 64'd0);
    tick();
    chk("t4_start_ignored", 64'(busy), 64'd0);

    // 5a: gapped input, batch 3: 1.0 + 2.0 + 3.0 = 6.0
    do_start(8'd3, 4'd0);
    expect_out(mk(16'h1800, 16'h1800, 16'h1800, 16'h1800));
    send(16'h0400, mk(16'h0400, 16'h0400, 16'h0400, 16'h0400));
    tick();
    send(16'h0400, mk(16'h0800, 16'h0800, 16'h0800, 16'h0800));
    tick();
    send(16'h0400, mk(16'h0C00, 16'h0C00, 16'h0C00, 16'h0C00));
    wait_out(n);
    accept();

    // 5b: cfg_batch=0 acts as 1; extra valid samples are not taken;
    // out_ready already high when out_valid rises
    out_ready = 1'b1;
    do_start(8'd0, 4'd0);
    expect_out(mk(16'h0400, 16'h0400, 16'h0400, 16'h0400));
    send(16'h0400, mk(16'h0400, 16'h0400, 16'h0400, 16'h0400));
    delta    = 16'h0400;
    a_in     = mk(16'h0400, 16'h0400, 16'h0400, 16'h0400);
    in_valid = 1'b1;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("t5b_back_idle", 64'(busy), 64'd0);
    chk("t5b_out_seen", 64'(popped), 64'(pushed));

    // 6: reset mid-batch discards accumulated samples
    do_start(8'd4, 4'd0);
    send(16'h0400, mk(16'h0400, 16'h0400, 16'h0400, 16'h0400));
    send(16'h0400, mk(16'h0400, 16'h0400, 16'h0400, 16'h0400));
    rst = 1'b1;
    tick();
    chk("t6_rst_in_ready", 64'(in_ready), 64'd0);
    chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_dw_out", dw_out, 64'd0);
    rst = 1'b0;
    tick();
    do_start(8'd2, 4'd0);
    expect_out(mk(16'h0800, 16'h0800, 16'h0800, 16'h0800));
    send(16'h0400, mk(16'h0400, 16'h0400, 16'h0400, 16'h0400));
    send(16'h0400, mk(16'h0400, 16'h0400, 16'h0400, 16'h0400));
    wait_out(n);
    accept();

    tick();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    chk("sb_pop_count", 64'(popped), 64'(pushed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
